// File: rtl/sparse_operand_aligner_pkg.sv
// sparse_operand_aligner shared definitions
// default geometry, derived widths, FSM encoding, popcount helper
package sparse_aligner_pkg;

  localparam int DEF_TRANSFER_SIZE = 4;
  localparam int DEF_CLUSTER_BITWIDTH = 8;
  localparam int DEF_COMPRESSION_WINDOW_SIZE = 32;

  localparam int COUNT_BITWIDTH =
    $clog2(DEF_TRANSFER_SIZE);
  localparam int WINDOW_INDEX_BITWIDTH =
    $clog2(DEF_COMPRESSION_WINDOW_SIZE) + 1;
  localparam int BEAT_BITWIDTH =
    DEF_TRANSFER_SIZE * DEF_CLUSTER_BITWIDTH;

  // widest mask the popcount helper accepts
  localparam int MAX_MASK_BITWIDTH = 1024;
  localparam int POP_BITWIDTH =
    $clog2(MAX_MASK_BITWIDTH) + 1;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t STREAM = 2'd1;
  localparam state_t FLUSH  = 2'd2;

  function automatic logic [POP_BITWIDTH-1:0] popcount(
    input logic [MAX_MASK_BITWIDTH-1:0] v
  );
    logic [POP_BITWIDTH-1:0] n;
    n = '0;
    for (int i = 0; i < MAX_MASK_BITWIDTH; i++) begin
      n = n + POP_BITWIDTH'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/sparse_operand_aligner_if.sv
// sparse_operand_aligner handshake bundle
// header, compressed block and dense beat channels
interface sparse_operand_aligner_if
  import sparse_aligner_pkg::*;
#(
  parameter int TRANSFER_SIZE = DEF_TRANSFER_SIZE,
  parameter int CLUSTER_BITWIDTH = DEF_CLUSTER_BITWIDTH,
  parameter int COMPRESSION_WINDOW_SIZE =
    DEF_COMPRESSION_WINDOW_SIZE
);

  localparam int BW = TRANSFER_SIZE * CLUSTER_BITWIDTH;

  logic [COMPRESSION_WINDOW_SIZE-1:0] hdrBitmask;
  logic [COMPRESSION_WINDOW_SIZE-1:0] hdrMutualBitmask;
  logic                               hdrValid;
  logic                               hdrReady;
  logic [BW-1:0]                      inData;
  logic                               inValid;
  logic                               inReady;
  logic [BW-1:0]                      outOperands;
  logic [TRANSFER_SIZE-1:0]           outLaneMask;
  logic                               outLast;
  logic                               outValid;
  logic                               outReady;

  modport master (
    output hdrBitmask, hdrMutualBitmask, hdrValid,
    output inData, inValid, outReady,
    input  hdrReady, inReady,
    input  outOperands, outLaneMask, outLast, outValid
  );

  modport slave (
    input  hdrBitmask, hdrMutualBitmask, hdrValid,
    input  inData, inValid, outReady,
    output hdrReady, inReady,
    output outOperands, outLaneMask, outLast, outValid
  );

endinterface

// File: rtl/sparse_operand_aligner_block.sv
// sparse_block_selector: maps one compressed block onto
// bitmask positions and compacts the mutual survivors
module sparse_block_selector
  import sparse_aligner_pkg::*;
#(
  parameter int TRANSFER_SIZE = DEF_TRANSFER_SIZE,
  parameter int CLUSTER_BITWIDTH = DEF_CLUSTER_BITWIDTH,
  parameter int COMPRESSION_WINDOW_SIZE =
    DEF_COMPRESSION_WINDOW_SIZE,
  localparam int TS = TRANSFER_SIZE,
  localparam int CB = CLUSTER_BITWIDTH,
  localparam int CWS = COMPRESSION_WINDOW_SIZE,
  localparam int BW = TS * CB,
  localparam int KC_W = $clog2(TS) + 1,
  localparam int PTR_W = $clog2(CWS) + 1
) (
  input  logic [CWS-1:0]   bitmask,
  input  logic [CWS-1:0]   mutual,
  input  logic [PTR_W-1:0] ptr,
  input  logic [BW-1:0]    block,
  output logic [BW-1:0]    kept,
  output logic [KC_W-1:0]  kept_cnt,
  output logic [PTR_W-1:0] ptr_nxt
);

  always_comb begin
    int idx;
    int cnt;
    idx = 0;
    cnt = 0;
    kept = '0;
    ptr_nxt = ptr;
    for (int p = 0; p < CWS; p++) begin
      if (p >= int'(ptr) && bitmask[p] && idx < TS) begin
        if (mutual[p]) begin
          kept[cnt*CB +: CB] = block[idx*CB +: CB];
          cnt = cnt + 1;
        end
        idx = idx + 1;
        ptr_nxt = PTR_W'(p + 1);
      end
    end
    kept_cnt = KC_W'(cnt);
  end

endmodule

// File: rtl/sparse_operand_aligner.sv
// sparse_operand_aligner: window FSM, leftover buffer
// and registered dense beat output
module sparse_operand_aligner
  import sparse_aligner_pkg::*;
#(
  parameter int TRANSFER_SIZE = DEF_TRANSFER_SIZE,
  parameter int CLUSTER_BITWIDTH = DEF_CLUSTER_BITWIDTH,
  parameter int COMPRESSION_WINDOW_SIZE =
    DEF_COMPRESSION_WINDOW_SIZE
) (
  input  logic clock,
  input  logic resetn,
  sparse_operand_aligner_if.slave bus,
  output logic busy
);

  localparam int TS = TRANSFER_SIZE;
  localparam int CB = CLUSTER_BITWIDTH;
  localparam int CWS = COMPRESSION_WINDOW_SIZE;
  localparam int BW = TS * CB;
  localparam int CNT_W = $clog2(TS);
  localparam int KC_W = CNT_W + 1;
  localparam int PTR_W = $clog2(CWS) + 1;

  state_t             state_q, state_d;
  logic               rdy_q, rdy_d;
  logic [CWS-1:0]     mask_q, mask_d;
  logic [CWS-1:0]     mut_q, mut_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   win_idx_q, win_idx_d;
  logic [PTR_W-1:0]   blk_total_q, blk_total_d;
  logic [BW-1:0]      lo_q, lo_d;
  logic [CNT_W-1:0]   lo_cnt_q, lo_cnt_d;
  logic [BW-1:0]      out_data_q, out_data_d;
  logic [TS-1:0]      out_mask_q, out_mask_d;
  logic               out_last_q, out_last_d;
  logic               out_valid_q, out_valid_d;

  logic [BW-1:0]           kept;
  logic [KC_W-1:0]         kept_cnt;
  logic [KC_W-1:0]         total;
  logic [PTR_W-1:0]        ptr_nxt;
  logic [2*BW-1:0]         merged;
  logic [TS-1:0]           lo_lanes;
  logic [POP_BITWIDTH-1:0] hdr_pop;
  logic [PTR_W-1:0]        hdr_blocks;
  logic hdr_fire, in_fire, out_free;
  logic full, exact, last_blk;

  sparse_block_selector #(
    .TRANSFER_SIZE(TS),
    .CLUSTER_BITWIDTH(CB),
    .COMPRESSION_WINDOW_SIZE(CWS)
  ) u_sel (
    .bitmask(mask_q),
    .mutual(mut_q),
    .ptr(ptr_q),
    .block(bus.inData),
    .kept(kept),
    .kept_cnt(kept_cnt),
    .ptr_nxt(ptr_nxt)
  );

  assign out_free = !out_valid_q || bus.outReady;
  assign bus.hdrReady = (state_q == IDLE) && rdy_q;
  assign bus.inReady = (state_q == STREAM) && out_free;
  assign hdr_fire = bus.hdrValid && bus.hdrReady;
  assign in_fire = bus.inValid && bus.inReady;

  assign bus.outOperands = out_data_q;
  assign bus.outLaneMask = out_mask_q;
  assign bus.outLast = out_last_q;
  assign bus.outValid = out_valid_q;
  assign busy = (state_q != IDLE);

  assign hdr_pop =
    popcount(MAX_MASK_BITWIDTH'(bus.hdrBitmask));
  assign hdr_blocks = PTR_W'(
    (hdr_pop + POP_BITWIDTH'(TS - 1)) >> CNT_W);

  // survivors land directly above the leftovers
  assign merged = {{BW{1'b0}}, lo_q} |
    ({{BW{1'b0}}, kept} << (int'(lo_cnt_q) * CB));
  assign total = KC_W'(lo_cnt_q) + kept_cnt;
  assign full = total >= KC_W'(TS);
  assign exact = total == KC_W'(TS);
  assign last_blk =
    win_idx_q == (blk_total_q - PTR_W'(1));

  always_comb begin
    lo_lanes = '0;
    for (int i = 0; i < TS; i++) begin
      lo_lanes[i] = i < int'(lo_cnt_q);
    end
  end

  always_comb begin
    state_d = state_q;
    rdy_d = 1'b1;
    mask_d = mask_q;
    mut_d = mut_q;
    ptr_d = ptr_q;
    win_idx_d = win_idx_q;
    blk_total_d = blk_total_q;
    lo_d = lo_q;
    lo_cnt_d = lo_cnt_q;
    out_data_d = out_data_q;
    out_mask_d = out_mask_q;
    out_last_d = out_last_q;
    out_valid_d = out_valid_q && !bus.outReady;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (hdr_fire) begin
          mask_d = bus.hdrBitmask;
          mut_d = bus.hdrMutualBitmask & bus.hdrBitmask;
          ptr_d = '0;
          win_idx_d = '0;
          blk_total_d = hdr_blocks;
          lo_d = '0;
          lo_cnt_d = '0;
          state_d = (hdr_pop == '0) ? FLUSH : STREAM;
        end
      end
      (state_q == STREAM): begin
        if (in_fire) begin
          ptr_d = ptr_nxt;
          win_idx_d = win_idx_q + PTR_W'(1);
          if (full) begin
            out_data_d = merged[BW-1:0];
            out_mask_d = '1;
            out_last_d = last_blk && exact;
            out_valid_d = 1'b1;
            lo_d = merged[2*BW-1:BW];
            lo_cnt_d = CNT_W'(total - KC_W'(TS));
          end else begin
            lo_d = merged[BW-1:0];
            lo_cnt_d = CNT_W'(total);
          end
          if (last_blk) begin
            state_d = (full && exact) ? IDLE : FLUSH;
          end
        end
      end
      (state_q == FLUSH): begin
        if (out_free) begin
          out_data_d = lo_q;
          out_mask_d = lo_lanes;
          out_last_d = 1'b1;
          out_valid_d = 1'b1;
          lo_d = '0;
          lo_cnt_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      rdy_q <= 1'b0;
      mask_q <= '0;
      mut_q <= '0;
      ptr_q <= '0;
      win_idx_q <= '0;
      blk_total_q <= '0;
      lo_q <= '0;
      lo_cnt_q <= '0;
      out_data_q <= '0;
      out_mask_q <= '0;
      out_last_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q <= rdy_d;
      mask_q <= mask_d;
      mut_q <= mut_d;
      ptr_q <= ptr_d;
      win_idx_q <= win_idx_d;
      blk_total_q <= blk_total_d;
      lo_q <= lo_d;
      lo_cnt_q <= lo_cnt_d;
      out_data_q <= out_data_d;
      out_mask_q <= out_mask_d;
      out_last_q <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_sparse_operand_aligner.sv
// tb_sparse_operand_aligner: directed windows with a
// scoreboard queue and a decoupled output monitor
module tb_sparse_operand_aligner;
  import sparse_aligner_pkg::*;

  localparam int TS = 4;
  localparam int CB = 8;
  localparam int CWS = 32;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  mask;
    logic        last;
  } beat_t;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic busy;

  beat_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int beats = 0;
  int in_rdy_seen = 0;
  bit empty_phase = 1'b0;

  sparse_operand_aligner_if #(
    .TRANSFER_SIZE(TS),
    .CLUSTER_BITWIDTH(CB),
    .COMPRESSION_WINDOW_SIZE(CWS)
  ) bus ();

  sparse_operand_aligner #(
    .TRANSFER_SIZE(TS),
    .CLUSTER_BITWIDTH(CB),
    .COMPRESSION_WINDOW_SIZE(CWS)
  ) dut (
    .clock(clock),
    .resetn(resetn),
    .bus(bus),
    .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] d,
                      input logic [3:0] m,
                      input logic l);
    beat_t b;
    b.data = d;
    b.mask = m;
    b.last = l;
    exp_q.push_back(b);
  endtask

  function automatic logic [31:0] blk(input int k);
    return {8'(4*k+4), 8'(4*k+3), 8'(4*k+2), 8'(4*k+1)};
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_hdrReady"}, 64'(bus.hdrReady), 64'(0));
    chk({tag, "_inReady"}, 64'(bus.inReady), 64'(0));
    chk({tag, "_outValid"}, 64'(bus.outValid), 64'(0));
    chk({tag, "_outLast"}, 64'(bus.outLast), 64'(0));
    chk({tag, "_outLaneMask"},
        64'(bus.outLaneMask), 64'(0));
    chk({tag, "_outOperands"},
        64'(bus.outOperands), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
  endtask

  task automatic send_hdr(input logic [31:0] bm,
                          input logic [31:0] mu,
                          output int waits);
    logic ok;
    ok = 1'b0;
    waits = 0;
    bus.hdrBitmask = bm;
    bus.hdrMutualBitmask = mu;
    bus.hdrValid = 1'b1;
    while (!ok && waits < 200) begin
      @(negedge clock);
      ok = bus.hdrReady;
      @(posedge clock);
      #1;
      waits++;
    end
    bus.hdrValid = 1'b0;
    chk("hdr_accept", 64'(ok), 64'(1));
  endtask

  task automatic send_blk(input logic [31:0] d);
    logic ok;
    int n;
    ok = 1'b0;
    n = 0;
    bus.inData = d;
    bus.inValid = 1'b1;
    while (!ok && n < 200) begin
      @(negedge clock);
      ok = bus.inReady;
      @(posedge clock);
      #1;
      n++;
    end
    bus.inValid = 1'b0;
    chk("blk_accept", 64'(ok), 64'(1));
  endtask

  task automatic dense_beats();
    push(blk(0), 4'hF, 1'b0);
    push(blk(3), 4'hF, 1'b0);
    push(blk(4), 4'hF, 1'b0);
    push(blk(7), 4'hF, 1'b1);
  endtask

  always @(negedge clock) begin
    beat_t got;
    beat_t want;
    if (resetn && bus.outValid && bus.outReady) begin
      got = {bus.outOperands, bus.outLaneMask,
             bus.outLast};
      beats++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got %h expected none",
                 got);
      end else begin
        want = exp_q.pop_front();
        chk("beat", 64'(got), 64'(want));
      end
    end
    if (empty_phase && bus.inReady) in_rdy_seen++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    beat_t snap;
    bus.hdrBitmask = '0;
    bus.hdrMutualBitmask = '0;
    bus.hdrValid = 1'b0;
    bus.inData = '0;
    bus.inValid = 1'b0;
    bus.outReady = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk_reset("por");
    @(posedge clock);
    #1 resetn = 1'b1;
    @(negedge clock);
    @(negedge clock);
    chk("hdr_ready_rise", 64'(bus.hdrReady), 64'(1));
    @(posedge clock);
    #1;

    dense_beats();
    send_hdr(32'hFFFFFFFF, 32'hF00FF00F, w);
    chk("busy_stream", 64'(busy), 64'(1));
    for (int k = 0; k < 8; k++) send_blk(blk(k));

    push(32'h08060402, 4'hF, 1'b1);
    send_hdr(32'h000000FF, 32'h000000AA, w);
    send_blk(blk(0));
    send_blk(blk(1));

    push(32'h00030201, 4'h7, 1'b1);
    send_hdr(32'hFFFFFFFF, 32'h00000007, w);
    for (int k = 0; k < 8; k++) send_blk(blk(k));

    push(32'h0, 4'h0, 1'b1);
    empty_phase = 1'b1;
    send_hdr(32'h0, 32'h0, w);
    push(32'h08060402, 4'hF, 1'b1);
    send_hdr(32'h000000FF, 32'h000000AA, w);
    empty_phase = 1'b0;
    chk("empty_next_hdr_wait", 64'(w), 64'(2));
    chk("empty_no_in_ready", 64'(in_rdy_seen), 64'(0));
    send_blk(blk(0));
    send_blk(blk(1));

    dense_beats();
    send_hdr(32'hFFFFFFFF, 32'hF00FF00F, w);
    bus.outReady = 1'b0;
    fork
      begin
        for (int k = 0; k < 8; k++) send_blk(blk(k));
      end
      begin
        int n;
        n = 0;
        do begin
          @(negedge clock);
          n++;
        end while (!bus.outValid && n < 50);
        chk("bp_valid", 64'(bus.outValid), 64'(1));
        snap = {bus.outOperands, bus.outLaneMask,
                bus.outLast};
        repeat (5) begin
          @(negedge clock);
          chk("bp_stable",
              64'({bus.outOperands, bus.outLaneMask,
                   bus.outLast, bus.outValid,
                   bus.inReady}),
              64'({snap, 1'b1, 1'b0}));
        end
        @(posedge clock);
        #1 bus.outReady = 1'b1;
      end
    join

    push(blk(0), 4'hF, 1'b0);
    send_hdr(32'hFFFFFFFF, 32'hF00FF00F, w);
    for (int k = 0; k < 3; k++) send_blk(blk(k));
    resetn = 1'b0;
    #1;
    chk_reset("mid");
    chk("mid_queue_empty", 64'(exp_q.size()), 64'(0));
    repeat (2) @(posedge clock);
    #1 resetn = 1'b1;

    push(32'h08060402, 4'hF, 1'b1);
    send_hdr(32'h000000FF, 32'h000000AA, w);
    send_blk(blk(0));
    send_blk(blk(1));

    repeat (10) @(negedge clock);
    chk("drain_empty", 64'(exp_q.size()), 64'(0));
    chk("beat_count", 64'(beats), 64'(14));
    chk("final_busy", 64'(busy), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/sparse_operand_aligner.md
Name: sparse_operand_aligner

Overview:
- Sequential, parametrised successor to the combinational mask-accumulate / mask-filter / buffer-update chain.
- Per compression window, accepts a header (own bitmask, mutual bitmask), then the compressed transfer-block stream.
- Drops clusters whose position is not in the mutual bitmask, repacks survivors into dense TRANSFER_SIZE-wide MAC operand beats, and marks the window's final beat.
- Sits between the compressed-weight/activation FIFO and the PE MAC array; valid/ready on all three interfaces.

Parameters:
TRANSFER_SIZE, 4, clusters per transfer block and per output beat (power of 2, >=2)
CLUSTER_BITWIDTH, 8, bits per cluster
COMPRESSION_WINDOW_SIZE, 32, bitmask length (multiple of TRANSFER_SIZE)

Ports:
clock  in  1  single clock, all state on posedge
resetn  in  1  asynchronous active-low reset
hdrBitmask  in  COMPRESSION_WINDOW_SIZE  own nonzero pattern of the window
hdrMutualBitmask  in  COMPRESSION_WINDOW_SIZE  positions where both operands are nonzero
hdrValid  in  1  header valid
hdrReady  out  1  header accepted when hdrValid&hdrReady
inData  in  TRANSFER_SIZE*CLUSTER_BITWIDTH  compressed block, cluster 0 in LSBs
inValid  in  1  block valid
inReady  out  1  block accepted when inValid&inReady
outOperands  out  TRANSFER_SIZE*CLUSTER_BITWIDTH  dense operands, lane 0 in LSBs
outLaneMask  out  TRANSFER_SIZE  valid lanes, always contiguous from lane 0
outLast  out  1  final beat of the window
outValid  out  1  beat valid
outReady  in  1  beat consumed when outValid&outReady
busy  out  1  high outside IDLE

Behaviour:
- Reset values: hdrReady=0, inReady=0, outValid=0, outLast=0, outLaneMask=0, outOperands=0, busy=0. Internal state: IDLE, leftover count 0, window index 0.
- Reset is legal in any state; the partial window is discarded, with no residual beat after release. hdrReady rises the first cycle after deassertion.
- Effective mutual mask = hdrMutualBitmask & hdrBitmask; stray mutual bits are ignored.
- Window block count = ceil(popcount(hdrBitmask)/TRANSFER_SIZE). The last block's upper clusters beyond the popcount are padding and are ignored.
- FSM:
  - IDLE: hdrReady=1. On header accept, latch both masks, clear the position pointer. Go to STREAM, or to FLUSH if popcount(hdrBitmask)=0.
  - STREAM: inReady = !outValid | outReady. Per accepted block:
    - Map the block's clusters to the next TRANSFER_SIZE set-bit positions of the bitmask at or above the pointer.
    - Keep clusters whose position is mutual, in order, and append them to leftovers.
    - Advance the pointer past the last mapped position.
    - If total >= TRANSFER_SIZE, register one full beat (laneMask all ones) and retain the excess (< TRANSFER_SIZE).
    - On the final block, go to FLUSH.
  - FLUSH: emit the remaining leftovers as one beat with outLast=1, then return to IDLE.
    - If leftovers are 0 and the final block produced a full beat, that beat carries outLast=1 and no extra beat follows.
    - If no beat was produced in the window at all, emit one beat with laneMask=0 and outLast=1.
- Every window ends with exactly one outLast beat.
- Latency: output is registered; a beat is valid the cycle after its completing block is accepted. Throughput is one block per cycle when outReady=1.
- Backpressure: while outValid & !outReady, the out* ports hold stable and inReady=0. Deasserting outValid without a handshake is illegal.
- Lanes above the laneMask are driven 0.
- Widths: leftover count is clog2(TRANSFER_SIZE) bits; pointer is clog2(COMPRESSION_WINDOW_SIZE)+1 bits, with no wrap inside a window.
- A new header is accepted only in IDLE. Back-to-back windows are allowed: IDLE is entered the cycle the last beat is registered, and the next header may be accepted then.

Decomposition:
- Package sparse_aligner_pkg holds:
  - derived widths: COUNT_BITWIDTH, WINDOW_INDEX_BITWIDTH, BEAT_BITWIDTH;
  - FSM state enum {IDLE, STREAM, FLUSH};
  - helper function for popcount.
- One sub-module, sparse_block_selector, is combinational:
  - inputs: masks, pointer, block;
  - outputs: compacted kept clusters, kept count, next pointer.
- The top module holds the FSM, leftover buffer and output register.

Test Plan:
- Dense window: bitmask 32'hFFFFFFFF, mutual 32'hF00FF00F, 8 blocks 32'h04030201..32'h201F1E1D -> 4 beats {04030201},{100F0E0D},{14131211},{201F1E1D}, laneMask 4'hF, outLast on beat 4 only.
- Cross-block repack: bitmask 32'h000000FF, mutual 32'h000000AA, blocks 32'h04030201, 32'h08070605 -> one beat 32'h08060402, laneMask 4'hF, outLast=1.
- Partial flush: bitmask 32'hFFFFFFFF, mutual 32'h00000007, 8 blocks -> single beat 32'h00030201, laneMask 4'h7, outLast=1, emitted after the 8th block.
- Empty window: bitmask 0 -> no inReady cycles, one beat laneMask 0, outLast=1; the next header is accepted the following cycle.
- Backpressure: dense window with outReady low for 5 cycles mid-window -> out* stable, inReady=0, no beat lost or duplicated, same 4 beats.
- Reset: assert resetn=0 after 3 blocks of the dense window -> all outputs go to 0 immediately. The next window yields exactly its own beats.
